// File: rtl/ahb_lite_fifo_subordinate.sv
// rtl/ahb_lite_fifo_subordinate.sv - AHB-Lite subordinate with TX/RX byte FIFOs behind one data window
// Wait states on FIFO full/empty, bounded by TIMEOUT, ending in a two-cycle ERROR response.
module ahb_lite_fifo_subordinate #(
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 255,
  parameter int ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic [2:0]        hsize,
  input  logic              hwrite,
  input  logic [31:0]       hwdata,
  output logic [31:0]       hrdata,
  output logic              hready,
  output logic              hresp,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [31:0]       status_in,
  output logic [31:0]       ctrl_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 2) : 1;
  localparam logic [7:0] DEPTH8 = 8'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t        state_q, state_d;
  logic [3:0]    addr_q, addr_d;
  logic [2:0]    size_q, size_d;
  logic          write_q, write_d;
  logic          hready_q, hready_d;
  logic          hresp_q, hresp_d;
  logic [31:0]   ctrl_q, ctrl_d;
  logic [31:0]   ext_q, ext_d;
  logic          tmo_flag_q, tmo_flag_d;
  logic          err_flag_q, err_flag_d;
  logic [SW-1:0] stall_q, stall_d;
  logic [AW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [AW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [7:0]    tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [7:0]    rx_mem [FIFO_DEPTH];

  logic        accept, in_phase, done, stall, tmo, is_win;
  logic        bus_push, bus_pop, ctrl_wr, flush, clr, tx_pop, rx_push;
  logic [2:0]  nb;
  logic [1:0]  base;
  logic [3:0]  lane_en;
  logic [7:0]  push_byte [4];
  logic [31:0] rdata;

  function automatic logic [2:0] size_bytes(input logic [2:0] sz);
    return 3'd1 << sz[1:0];
  endfunction

  function automatic logic addr_error(input logic [ADDR_W-1:0] a, input logic [2:0] sz,
                                      input logic wr);
    logic misaligned;
    misaligned = (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'd0);
    return (a[ADDR_W-1:4] != '0) || (sz > 3'd2) || misaligned ||
           (wr && (a[3:2] == 2'd1 || a[3:2] == 2'd2));
  endfunction

  // Whether a data phase for this access can finish given the registered FIFO counts.
  function automatic logic can_complete(input logic [3:0] a, input logic [2:0] sz, input logic wr,
                                        input logic [7:0] txc, input logic [7:0] rxc);
    logic [7:0] n;
    n = {5'd0, size_bytes(sz)};
    if (a[3:2] != 2'd0) return 1'b1;
    if (wr) return (DEPTH8 - txc) >= n;
    return rxc >= n;
  endfunction

  always_comb begin
    accept   = hsel && hready_q && htrans[1];
    in_phase = (state_q == S_DATA) || (state_q == S_WAIT);
    done     = in_phase && hready_q;
    stall    = in_phase && !hready_q;
    tmo      = stall && (TIMEOUT != 0) && (int'(stall_q) + 1 >= TIMEOUT);
    is_win   = addr_q[3:2] == 2'd0;
    nb       = size_bytes(size_q);
    base     = addr_q[1:0];
    bus_push = done && write_q && is_win;
    bus_pop  = done && !write_q && is_win;
    ctrl_wr  = done && write_q && addr_q[3:2] == 2'd3;
    tx_pop   = (tx_cnt_q != 8'd0) && tx_ready;
    rx_push  = rx_valid && (rx_cnt_q != DEPTH8);

    for (int l = 0; l < 4; l++) begin
      lane_en[l]   = (3'(l) >= {1'b0, base}) && (3'(l) < {1'b0, base} + nb);
      push_byte[l] = hwdata[8*(base + 2'(l)) +: 8];
    end

    flush = ctrl_wr && lane_en[0] && hwdata[0];
    clr   = ctrl_wr && lane_en[0] && hwdata[1];

    ctrl_d = ctrl_q;
    for (int l = 0; l < 4; l++)
      if (ctrl_wr && lane_en[l]) ctrl_d[8*l +: 8] = hwdata[8*l +: 8];
    ctrl_d[1:0] = 2'b00;

    tx_cnt_d = tx_cnt_q + (bus_push ? {5'd0, nb} : 8'd0) - {7'd0, tx_pop};
    tx_wr_d  = tx_wr_q + (bus_push ? AW'(nb) : '0);
    tx_rd_d  = tx_rd_q + AW'(tx_pop);
    rx_cnt_d = rx_cnt_q + {7'd0, rx_push} - (bus_pop ? {5'd0, nb} : 8'd0);
    rx_wr_d  = rx_wr_q + AW'(rx_push);
    rx_rd_d  = rx_rd_q + (bus_pop ? AW'(nb) : '0);
    if (flush) begin
      tx_cnt_d = 8'd0; tx_wr_d = '0; tx_rd_d = '0;
      rx_cnt_d = 8'd0; rx_wr_d = '0; rx_rd_d = '0;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    write_d    = write_q;
    stall_d    = stall_q;
    ext_d      = ext_q;
    tmo_flag_d = tmo_flag_q;
    err_flag_d = err_flag_q;
    if (accept) begin
      addr_d  = haddr[3:0];
      size_d  = hsize;
      write_d = hwrite;
      ext_d   = status_in;
      stall_d = '0;
      state_d = addr_error(haddr, hsize, hwrite) ? S_ERR1 : S_DATA;
    end else begin
      case (state_q)
        S_DATA, S_WAIT: begin
          if (done) state_d = S_IDLE;
          else if (tmo) begin
            state_d    = S_ERR1;
            tmo_flag_d = 1'b1;
          end else begin
            state_d = S_WAIT;
            stall_d = stall_q + SW'(1);
          end
        end
        S_ERR1:  state_d = S_ERR2;
        default: state_d = S_IDLE;
      endcase
    end
    if (state_q == S_ERR2) err_flag_d = 1'b1;
    if (clr) begin
      tmo_flag_d = 1'b0;
      err_flag_d = 1'b0;
    end
    // hready is precomputed from next-state counts so it is a clean flop output.
    hresp_d = (state_d == S_ERR1) || (state_d == S_ERR2);
    case (state_d)
      S_DATA, S_WAIT: hready_d = can_complete(addr_d, size_d, write_d, tx_cnt_d, rx_cnt_d);
      S_ERR1:         hready_d = 1'b0;
      default:        hready_d = 1'b1;
    endcase
  end

  always_comb begin
    rdata = '0;
    if (in_phase && hready_q && !write_q) begin
      case (addr_q[3:2])
        2'd0: begin
          for (int i = 0; i < 4; i++) begin
            logic [1:0] lane;
            lane = base + 2'(i);
            if (3'(i) < nb) rdata[8*lane +: 8] = rx_mem[rx_rd_q + AW'(i)];
          end
        end
        2'd1:    rdata = {12'd0, err_flag_q, tmo_flag_q, rx_cnt_q == DEPTH8, tx_cnt_q == 8'd0,
                          rx_cnt_q, tx_cnt_q};
        2'd2:    rdata = ext_q;
        default: rdata = ctrl_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      size_q     <= '0;
      write_q    <= 1'b0;
      hready_q   <= 1'b1;
      hresp_q    <= 1'b0;
      ctrl_q     <= '0;
      ext_q      <= '0;
      tmo_flag_q <= 1'b0;
      err_flag_q <= 1'b0;
      stall_q    <= '0;
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      tx_cnt_q   <= '0;
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      rx_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      write_q    <= write_d;
      hready_q   <= hready_d;
      hresp_q    <= hresp_d;
      ctrl_q     <= ctrl_d;
      ext_q      <= ext_d;
      tmo_flag_q <= tmo_flag_d;
      err_flag_q <= err_flag_d;
      stall_q    <= stall_d;
      tx_wr_q    <= tx_wr_d;
      tx_rd_q    <= tx_rd_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_wr_q    <= rx_wr_d;
      rx_rd_q    <= rx_rd_d;
      rx_cnt_q   <= rx_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (bus_push && 3'(i) < nb) tx_mem[tx_wr_q + AW'(i)] <= push_byte[i];
    if (rx_push) rx_mem[rx_wr_q] <= rx_data;
  end

  assign hrdata   = rdata;
  assign hready   = hready_q;
  assign hresp    = hresp_q;
  assign tx_data  = tx_mem[tx_rd_q];
  assign tx_valid = tx_cnt_q != 8'd0;
  assign rx_ready = rx_cnt_q != DEPTH8;
  assign ctrl_out = ctrl_q;

endmodule

// File: tb/tb_ahb_lite_fifo_subordinate.sv
// tb/tb_ahb_lite_fifo_subordinate.sv - scoreboard bench for ahb_lite_fifo_subordinate
module tb_ahb_lite_fifo_subordinate;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel;
  logic [7:0]  haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hwrite;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] status_in;
  logic [31:0] ctrl_out;

  ahb_lite_fifo_subordinate #(.FIFO_DEPTH(16), .TIMEOUT(8), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .hsel(hsel), .haddr(haddr), .htrans(htrans), .hsize(hsize),
    .hwrite(hwrite), .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .status_in(status_in), .ctrl_out(ctrl_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        resp;
    logic        chk;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] tx_model[$];
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // One AHB transfer: expectation is queued at issue, popped when the data phase ends.
  task automatic xfer(input string tag, input logic wr, input logic [7:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_resp,
                      output int waits);
    exp_t e;
    logic saw_err1;
    int   guard;
    e.data = exp_rd; e.resp = exp_resp; e.chk = !wr;
    exp_q.push_back(e);
    hsel = 1'b1; haddr = a; htrans = 2'b10; hsize = sz; hwrite = wr;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = wd;
    waits = 0; saw_err1 = 1'b0; guard = 0;
    while (!hready && guard < 100) begin
      if (hresp) saw_err1 = 1'b1;
      else waits++;
      @(posedge clk); #1;
      guard++;
    end
    e = exp_q.pop_front();
    if (guard >= 100) check({tag, "_hang"}, guard, 0);
    check({tag, "_resp"}, hresp, e.resp);
    if (e.resp) check({tag, "_err1"}, saw_err1, 1);
    if (e.chk && !e.resp) check({tag, "_rdata"}, hrdata, e.data);
  endtask

  task automatic tx_write(input string tag, input logic [7:0] a, input logic [2:0] sz,
                          input logic [31:0] d, output int waits);
    int n;
    n = 1 << sz;
    for (int i = 0; i < n; i++) tx_model.push_back(d[8*(a[1:0] + i) +: 8]);
    xfer(tag, 1'b1, a, sz, d, 32'h0, 1'b0, waits);
  endtask

  task automatic rx_put(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      if (tx_model.size() == 0) check("tx_unexpected", tx_model.size(), 1);
      else check("tx_byte", tx_data, tx_model.pop_front());
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int w;
    rst = 1'b1; hsel = 1'b0; haddr = '0; htrans = 2'b00; hsize = 3'd0; hwrite = 1'b0;
    hwdata = '0; tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0; status_in = 32'hCAFE_0001;
    repeat (3) @(posedge clk); #1;
    check("rst_hready", hready, 1);
    check("rst_hresp", hresp, 0);
    check("rst_hrdata", hrdata, 0);
    check("rst_ctrl", ctrl_out, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_rx_ready", rx_ready, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    xfer("st_rst", 1'b0, 8'h04, 3'd2, 0, 32'h0001_0000, 1'b0, w);
    xfer("ext", 1'b0, 8'h08, 3'd2, 0, 32'hCAFE_0001, 1'b0, w);

    tx_write("t1", 8'h00, 3'd2, 32'h4433_2211, w);
    check("t1_waits", w, 0);
    xfer("t1_st4", 1'b0, 8'h04, 3'd2, 0, 32'h0000_0004, 1'b0, w);
    tx_ready = 1'b1;
    repeat (4) @(posedge clk); #1;
    tx_ready = 1'b0;
    check("t1_drained", tx_model.size(), 0);
    xfer("t1_st0", 1'b0, 8'h04, 3'd2, 0, 32'h0001_0000, 1'b0, w);

    tx_write("f0", 8'h00, 3'd2, 32'h0302_0100, w);
    tx_write("f1", 8'h00, 3'd2, 32'h0706_0504, w);
    tx_write("f2", 8'h00, 3'd2, 32'h0B0A_0908, w);
    tx_write("f3", 8'h00, 3'd1, 32'h0000_0D0C, w);
    xfer("f_st14", 1'b0, 8'h04, 3'd2, 0, 32'h0000_000E, 1'b0, w);
    fork
      tx_write("full", 8'h00, 3'd2, 32'h1312_1110, w);
      begin
        repeat (3) @(posedge clk); #1;
        tx_ready = 1'b1;
        repeat (2) @(posedge clk); #1;
        tx_ready = 1'b0;
      end
    join
    check("full_waits", w, 4);
    xfer("full_st16", 1'b0, 8'h04, 3'd2, 0, 32'h0000_0010, 1'b0, w);
    tx_ready = 1'b1;
    repeat (16) @(posedge clk); #1;
    tx_ready = 1'b0;
    check("full_drained", tx_model.size(), 0);
    xfer("full_st0", 1'b0, 8'h04, 3'd2, 0, 32'h0001_0000, 1'b0, w);

    rx_put(8'hA1);
    fork
      xfer("rx_half", 1'b0, 8'h02, 3'd1, 0, 32'hA2A1_0000, 1'b0, w);
      begin
        repeat (3) @(posedge clk); #1;
        rx_put(8'hA2);
      end
    join
    check("rx_half_waits", w, 3);
    for (int i = 0; i < 4; i++) rx_put(8'hB0 + 8'(i));
    xfer("rx_word", 1'b0, 8'h00, 3'd2, 0, 32'hB3B2_B1B0, 1'b0, w);
    check("rx_word_waits", w, 0);
    rx_put(8'hC0);
    xfer("rx_byte3", 1'b0, 8'h03, 3'd0, 0, 32'hC000_0000, 1'b0, w);
    xfer("rx_st0", 1'b0, 8'h04, 3'd2, 0, 32'h0001_0000, 1'b0, w);

    xfer("tmo", 1'b0, 8'h00, 3'd2, 0, 32'h0, 1'b1, w);
    check("tmo_waits", w, 8);
    xfer("tmo_st", 1'b0, 8'h04, 3'd2, 0, 32'h000D_0000, 1'b0, w);
    xfer("clr", 1'b1, 8'h0C, 3'd0, 32'h0000_0002, 32'h0, 1'b0, w);
    xfer("clr_st", 1'b0, 8'h04, 3'd2, 0, 32'h0001_0000, 1'b0, w);

    xfer("e_wr_status", 1'b1, 8'h04, 3'd2, 32'h1234_5678, 32'h0, 1'b1, w);
    xfer("e_unmapped", 1'b0, 8'h10, 3'd2, 0, 32'h0, 1'b1, w);
    xfer("e_misalign", 1'b0, 8'h01, 3'd1, 0, 32'h0, 1'b1, w);
    xfer("e_hsize3", 1'b0, 8'h00, 3'd3, 0, 32'h0, 1'b1, w);
    xfer("e_ctrl_rd", 1'b0, 8'h0C, 3'd2, 0, 32'h0, 1'b0, w);

    xfer("ctrl_w", 1'b1, 8'h0C, 3'd2, 32'hA5A5_A5A4, 32'h0, 1'b0, w);
    xfer("ctrl_h", 1'b1, 8'h0E, 3'd1, 32'h1234_0000, 32'h0, 1'b0, w);
    xfer("ctrl_rd", 1'b0, 8'h0C, 3'd2, 0, 32'h1234_A5A4, 1'b0, w);

    tx_write("fl_tx", 8'h00, 3'd2, 32'hDEAD_BEEF, w);
    rx_put(8'hE0);
    rx_put(8'hE1);
    xfer("fl_st_pre", 1'b0, 8'h04, 3'd2, 0, 32'h0008_0204, 1'b0, w);
    xfer("fl_ctrl", 1'b1, 8'h0C, 3'd2, 32'h0000_0005, 32'h0, 1'b0, w);
    tx_model.delete();
    xfer("fl_st_post", 1'b0, 8'h04, 3'd2, 0, 32'h0009_0000, 1'b0, w);
    xfer("fl_ctrl_rd", 1'b0, 8'h0C, 3'd2, 0, 32'h0000_0004, 1'b0, w);
    check("fl_ctrl_out", ctrl_out, 32'h0000_0004);
    tx_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("fl_tx_valid", tx_valid, 0);
    tx_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
